bram_port_arbiter: RTL and testbench

Shares the 1024x16 dual-port block RAM between NUM_REQ requesters, using round-robin arbitration.
- Grants up to two requests per cycle, one on BRAM port A and one on port B.
- Blocks same-address write hazards across the two ports.
- Routes read data back to each requester at a fixed latency.
- Provides a hardware clear sequence that zeroes the whole RAM, two words per cycle.

---
 rtl/bram_port_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Purpose  : Round-robin sharing of a dual-port BRAM between NUM_REQ
//            requesters, with hazard blocking, fixed-latency read return
//            and a hardware clear sequence.
// Options  : define BRAM_ARB_STATS_EN to add the conflict_cnt output.
// Revision : 1.0
// ============================================================================
module bram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arb_en,
    input  logic                      init_start,
    output logic                      init_busy,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic                      wea,
    output logic                      web,
    output logic [ADDR_W-1:0]         addra,
    output logic [ADDR_W-1:0]         addrb,
    output logic [DATA_W-1:0]         dia,
    output logic [DATA_W-1:0]         dib,
    input  logic [DATA_W-1:0]         doa,
    input  logic [DATA_W-1:0]         dob
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [15:0]               conflict_cnt
`endif
);

    localparam int                   c_PTR_W    = $clog2(NUM_REQ);
    localparam logic [c_PTR_W:0]     c_NUM_REQ  = (c_PTR_W+1)'(NUM_REQ);
    localparam logic [c_PTR_W-1:0]   c_LAST_REQ = c_PTR_W'(NUM_REQ - 1);
    localparam logic [ADDR_W-2:0]    c_CLR_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                    r_state;
    logic [c_PTR_W-1:0]        r_ptr;
    logic [ADDR_W-2:0]         r_clr_k;
    logic                      r_busy;
    logic                      r_wea, r_web;
    logic [ADDR_W-1:0]         r_addra, r_addrb;
    logic [DATA_W-1:0]         r_dia, r_dib;
    logic [NUM_REQ-1:0]        r_p1_v, r_p1_b, r_p2_v, r_p2_b;
    logic [NUM_REQ*DATA_W-1:0] r_hold;

    logic [c_PTR_W:0]          w_idx;
    logic [c_PTR_W-1:0]        w_g1, w_g2, w_last, w_ptr_nxt;
    logic                      w_found1, w_found2;
    logic                      w_arb, w_hazard, w_gnt1, w_gnt2;
    logic                      w_we1, w_we2;
    logic [ADDR_W-1:0]         w_addr1, w_addr2;
    logic [DATA_W-1:0]         w_wdata1, w_wdata2;
    logic [NUM_REQ-1:0]        w_rd_v, w_rd_b;
    logic [ADDR_W-2:0]         w_clr_nxt;
    logic [NUM_REQ*DATA_W-1:0] w_sel;

    // Rotating scan from the pointer: first two active requesters.
    always_comb begin
        w_found1 = 1'b0;
        w_found2 = 1'b0;
        w_g1     = '0;
        w_g2     = '0;
        w_idx    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = {1'b0, r_ptr} + (c_PTR_W+1)'(off);
            if (w_idx >= c_NUM_REQ) begin
                w_idx = w_idx - c_NUM_REQ;
            end
            if (req[w_idx[c_PTR_W-1:0]]) begin
                if (!w_found1) begin
                    w_found1 = 1'b1;
                    w_g1     = w_idx[c_PTR_W-1:0];
                end else if (!w_found2) begin
                    w_found2 = 1'b1;
                    w_g2     = w_idx[c_PTR_W-1:0];
                end
            end
        end
    end

    assign w_we1    = req_we[w_g1];
    assign w_we2    = req_we[w_g2];
    assign w_addr1  = req_addr[w_g1*ADDR_W +: ADDR_W];
    assign w_addr2  = req_addr[w_g2*ADDR_W +: ADDR_W];
    assign w_wdata1 = req_wdata[w_g1*DATA_W +: DATA_W];
    assign w_wdata2 = req_wdata[w_g2*DATA_W +: DATA_W];

    // Gating with reset keeps gnt low while the block is held in reset.
    assign w_arb    = reset && (r_state == S_IDLE) && arb_en && !init_start;
    assign w_hazard = w_arb && w_found2 && (w_addr1 == w_addr2) && (w_we1 || w_we2);
    assign w_gnt1   = w_arb && w_found1;
    assign w_gnt2   = w_arb && w_found2 && !w_hazard;

    assign w_last    = w_gnt2 ? w_g2 : w_g1;
    assign w_ptr_nxt = (w_last == c_LAST_REQ) ? '0 : w_last + c_PTR_W'(1);
    assign w_clr_nxt = r_clr_k + (ADDR_W-1)'(1);

    always_comb begin
        gnt    = '0;
        w_rd_v = '0;
        w_rd_b = '0;
        if (w_gnt1) begin
            gnt[w_g1]    = 1'b1;
            w_rd_v[w_g1] = !w_we1;
        end
        if (w_gnt2) begin
            gnt[w_g2]    = 1'b1;
            w_rd_v[w_g2] = !w_we2;
            w_rd_b[w_g2] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_clr_k <= '0;
            r_busy  <= 1'b0;
            r_wea   <= 1'b0;
            r_web   <= 1'b0;
            r_addra <= '0;
            r_addrb <= '0;
            r_dia   <= '0;
            r_dib   <= '0;
            r_p1_v  <= '0;
            r_p1_b  <= '0;
            r_p2_v  <= '0;
            r_p2_b  <= '0;
            r_hold  <= '0;
        end else begin
            r_p1_v <= w_rd_v;
            r_p1_b <= w_rd_b;
            r_p2_v <= r_p1_v;
            r_p2_b <= r_p1_b;
            r_hold <= rsp_data;
            case (r_state)
                S_IDLE: begin
                    if (init_start) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_clr_k <= '0;
                        r_wea   <= 1'b1;
                        r_web   <= 1'b1;
                        r_addra <= '0;
                        r_addrb <= ADDR_W'(1);
                        r_dia   <= '0;
                        r_dib   <= '0;
                    end else begin
                        r_wea <= w_gnt1 && w_we1;
                        r_web <= w_gnt2 && w_we2;
                        if (w_gnt1) begin
                            r_addra <= w_addr1;
                            r_dia   <= w_wdata1;
                            r_ptr   <= w_ptr_nxt;
                        end
                        if (w_gnt2) begin
                            r_addrb <= w_addr2;
                            r_dib   <= w_wdata2;
                        end
                    end
                end
                // Port registers run one word pair ahead so the BRAM sees pair k in clear cycle k.
                S_CLEAR: begin
                    if (r_clr_k == c_CLR_LAST) begin
                        r_state <= S_DRAIN;
                        r_wea   <= 1'b0;
                        r_web   <= 1'b0;
                    end else begin
                        r_clr_k <= w_clr_nxt;
                        r_addra <= {w_clr_nxt, 1'b0};
                        r_addrb <= {w_clr_nxt, 1'b1};
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Read data is taken straight off the BRAM in the valid cycle, then held.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign w_sel[i*DATA_W +: DATA_W]    = r_p2_b[i] ? dob : doa;
        assign rsp_data[i*DATA_W +: DATA_W] = r_p2_v[i] ? w_sel[i*DATA_W +: DATA_W]
                                                        : r_hold[i*DATA_W +: DATA_W];
    end

    assign rsp_valid = r_p2_v;
    assign init_busy = r_busy;
    assign wea       = r_wea;
    assign web       = r_web;
    assign addra     = r_addra;
    assign addrb     = r_addrb;
    assign dia       = r_dia;
    assign dib       = r_dib;

`ifdef BRAM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conflict_cnt <= '0;
        end else if ((r_state == S_IDLE) && init_start) begin
            r_conflict_cnt <= '0;
        end else if (w_hazard && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Purpose  : Self-checking bench for bram_port_arbiter with a BRAM model and
//            a transaction-level reference of arbitration and read return.
// Revision : 1.0
// ============================================================================
module tb_bram_port_arbiter;

    localparam int N     = 4;
    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int DEPTH = 1024;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          arb_en     = 1'b0;
    logic          init_start = 1'b0;
    logic          init_busy;
    logic [N-1:0]  req        = '0;
    logic [N-1:0]  req_we     = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]  gnt, rsp_valid;
    logic [N*DW-1:0] rsp_data;
    logic          wea, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dia, dib, doa, dob;
`ifdef BRAM_ARB_STATS_EN
    logic [15:0]   conflict_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .arb_en(arb_en), .init_start(init_start),
        .init_busy(init_busy), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .wea(wea), .web(web), .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(doa), .dob(dob)
`ifdef BRAM_ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    // Dual-port BRAM, read-first, one clock of read latency.
    logic [DW-1:0] bram [DEPTH];
    always @(posedge clk) begin
        if (wea) bram[addra] <= dia;
        if (web) bram[addrb] <= dib;
        doa <= bram[addra];
        dob <= bram[addrb];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] la(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic [N-1:0]  ev [4];
    logic [DW-1:0] ed [4][N];
    logic [DW-1:0] m_hold [N];
    int            m_ptr  = 0;
    int            m_busy = 0;
    logic [15:0]   m_cnt  = '0;
    int            cyc    = 0;

    always @(negedge clk) begin
        logic [N-1:0]    eg, erv;
        logic [N*DW-1:0] erd;
        int              q[$];
        int              slot, g1, g2, last;
        logic            hz;
        if (cyc == 0) for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        slot = cyc % 4;
        if (!reset) begin
            chk("rst gnt", gnt, 0);
            chk("rst rsp_valid", rsp_valid, 0);
            chk("rst rsp_data", rsp_data, 0);
            chk("rst init_busy", init_busy, 0);
            chk("rst we", {wea, web}, 0);
`ifdef BRAM_ARB_STATS_EN
            chk("rst conflict_cnt", conflict_cnt, 0);
`endif
            m_ptr  = 0;
            m_busy = 0;
            m_cnt  = '0;
            for (int s = 0; s < 4; s++) ev[s] = '0;
            for (int i = 0; i < N; i++) m_hold[i] = '0;
        end else begin
            erv = ev[slot];
            for (int i = 0; i < N; i++) begin
                if (erv[i]) m_hold[i] = ed[slot][i];
                erd[i*DW +: DW] = m_hold[i];
            end
            ev[slot] = '0;
            chk("rsp_valid", rsp_valid, erv);
            chk("rsp_data", rsp_data, erd);
            chk("init_busy", init_busy, (m_busy > 0));
`ifdef BRAM_ARB_STATS_EN
            chk("conflict_cnt", conflict_cnt, m_cnt);
`endif
            eg = '0;
            hz = 1'b0;
            if (m_busy == 0 && arb_en && !init_start) begin
                q.delete();
                for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) q.push_back((m_ptr + k) % N);
                if (q.size() > 0) begin
                    g1 = q[0];
                    eg[g1] = 1'b1;
                    last = g1;
                    if (q.size() > 1) begin
                        g2 = q[1];
                        if (la(g1) == la(g2) && (req_we[g1] || req_we[g2])) hz = 1'b1;
                        else begin
                            eg[g2] = 1'b1;
                            last = g2;
                        end
                    end
                    m_ptr = (last + 1) % N;
                end
            end
            chk("gnt", gnt, eg);
            for (int i = 0; i < N; i++) begin
                if (eg[i] && !req_we[i]) begin
                    ev[(cyc + 2) % 4][i] = 1'b1;
                    ed[(cyc + 2) % 4][i] = ref_mem[la(i)];
                end
            end
            for (int i = 0; i < N; i++)
                if (eg[i] && req_we[i]) ref_mem[la(i)] = req_wdata[i*DW +: DW];
            if (m_busy > 0) m_busy--;
            else if (init_start) begin
                m_busy = 513;
                m_cnt  = '0;
                for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
            end
            if (hz && m_cnt != 16'hFFFF) m_cnt++;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req        = '0;
        req_we     = '0;
        init_start = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]                = 1'b1;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic rd_check(input int lane, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
        logic [DW-1:0] got;
        idle_inputs();
        set_lane(lane, 1'b0, a, '0);
        #3 chk({nm, " gnt"}, gnt, 64'(1) << lane);
        tick();
        idle_inputs();
        tick();
        #3 chk({nm, " valid"}, rsp_valid[lane], 1);
        got = rsp_data[lane*DW +: DW];
        chk({nm, " data"}, got, exp);
        tick();
    endtask

    initial begin
        int busy_cnt;
        reset  = 1'b0;
        arb_en = 1'b1;
        repeat (3) tick();
        reset = 1'b1;

        for (int c = 0; c < 20; c++) begin
            #3 chk("idle rsp_valid", rsp_valid, 0);
            tick();
        end

        // write then read back one word
        set_lane(0, 1'b1, 10'd5, 16'h1234);
        #3 chk("wr5 gnt", gnt, 4'b0001);
        tick();
        idle_inputs();
        tick();
        rd_check(0, 10'd5, 16'h1234, "rd5");

        // fill the whole RAM, two words per cycle
        for (int k = 0; k < 512; k++) begin
            idle_inputs();
            set_lane(0, 1'b1, AW'(2*k),   16'h8000 | 16'(2*k));
            set_lane(1, 1'b1, AW'(2*k+1), 16'h8000 | 16'(2*k+1));
            tick();
        end
        idle_inputs();
        tick();
        rd_check(2, 10'd777, 16'h8309, "rd777");

        // clear sequence; random read requests while busy must not be granted
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            req    = N'($urandom);
            req_we = '0;
            for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
            #3;
            if (!init_busy) break;
            busy_cnt++;
            if (c == 100) chk("clear gnt", gnt, 0);
            tick();
        end
        chk("busy cycles", busy_cnt, 513);
        tick();
        idle_inputs();
        tick();
        rd_check(0, 10'd0,    16'h0000, "clr0");
        rd_check(1, 10'd511,  16'h0000, "clr511");
        rd_check(2, 10'd1023, 16'h0000, "clr1023");

        // seed 100..103, reset, then four-lane continuous reads
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, AW'(100 + i), 16'h1100 + 16'(i));
        req = 4'b0011;
        tick();
        req = 4'b1100;
        tick();
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_lane(i, 1'b0, AW'(100 + i), '0);
            #3 chk("rr gnt", gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            tick();
        end
        idle_inputs();
        #3 chk("rr valid01", rsp_valid, 4'b0011);
        chk("rr data0", rsp_data[15:0], 16'h1100);
        chk("rr data1", rsp_data[31:16], 16'h1101);
        tick();
        #3 chk("rr valid23", rsp_valid, 4'b1100);
        chk("rr data3", rsp_data[63:48], 16'h1103);
        tick();

        // same-address write/read hazard
        set_lane(0, 1'b1, 10'd7, 16'hAAAA);
        set_lane(1, 1'b0, 10'd7, '0);
        #3 chk("hz gnt", gnt, 4'b0001);
        tick();
        idle_inputs();
        set_lane(1, 1'b0, 10'd7, '0);
        #3 chk("hz retry gnt", gnt, 4'b0010);
        tick();
        idle_inputs();
        tick();
        #3 chk("hz valid", rsp_valid, 4'b0010);
        chk("hz data", rsp_data[31:16], 16'hAAAA);
`ifdef BRAM_ARB_STATS_EN
        chk("hz conflict_cnt", conflict_cnt, 1);
`endif
        tick();

        // randomized traffic on a small address window
        for (int c = 0; c < 2000; c++) begin
            req    = N'($urandom);
            req_we = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
                req_wdata[i*DW +: DW] = DW'($urandom);
            end
            arb_en = ($urandom_range(0, 7) != 0);
            tick();
        end
        idle_inputs();
        arb_en = 1'b1;
        tick();
        tick();

        // reset one cycle after a read grant drops the response
        set_lane(2, 1'b0, 10'd7, '0);
        #3 chk("rstrd gnt", gnt, 4'b0100);
        tick();
        idle_inputs();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3 chk("rstrd no rsp", rsp_valid, 0);
            tick();
        end
        reset = 1'b1;
        for (int i = 0; i < N; i++) set_lane(i, 1'b0, AW'(i), '0);
        #3 chk("post-rst gnt", gnt, 4'b0011);
        tick();
        idle_inputs();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
